// File: rtl/instr_fetch_pkg.sv
// Shared constants for the instruction fetch stage.
package instr_fetch_pkg;

    localparam int          ADDR_W    = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch buffer: push/pop/flush, occupancy count and a head read from flops.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [WIDTH-1:0]           head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    // Qualify requests so the buffer can never over- or under-run.
    always_comb begin
        pop_ok   = pop_i & (count_q != '0);
        push_ok  = push_i & ((count_q != CW'(DEPTH)) | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Pointer/count registers and storage; a flush drops any same-cycle push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: drives the ROM address, tracks the one in-flight read and hands
// {instr, pc} pairs to decode through a small credit-controlled buffer.
module instr_fetch #(
    parameter int                ADDR_W     = instr_fetch_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(instr_fetch_pkg::RESET_PC),
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    import instr_fetch_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = INSTR_W + ADDR_W;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    logic [CW-1:0]     count;
    logic [EW-1:0]     head;
    logic [CW:0]       credit_sum;
    logic              pop;
    logic              issue;

    assign pop = out_valid & out_ready;

    // Issue only when the buffer can absorb every word already owed to it.
    always_comb begin
        credit_sum = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        issue      = fetch_en & ~redirect_valid & (credit_sum < (CW+1)'(FIFO_DEPTH));
    end

    // Next PC / in-flight tracking; a redirect overrides any issue.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
            pc_d          = pc_q + ADDR_W'(1);
        end
    end

    // PC and in-flight registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // The ROM word is only present for one cycle, so it is pushed unconditionally
    // when in flight; the flush input discards it if a redirect lands the same cycle.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .data_i  ({imem_instr, inflight_pc_q}),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .count_o (count),
        .head_o  (head)
    );

    assign imem_addr = pc_q;
    assign out_valid = (count != '0);
    assign out_instr = head[EW-1 -: INSTR_W];
    assign out_pc    = head[ADDR_W-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch with a registered ROM model and a
// scoreboard of expected {pc, instr} transfers.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [31:0] target;
        logic [31:0] first_instr;
        int          at_pc;
        bit          ready;
    } redir_vec_t;
    redir_vec_t vecs[5];

    bit          mon_en = 1'b0;
    bit          hold_q = 1'b0;
    bit          redir_q = 1'b0;
    logic [64:0] hold_val = '0;

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_instr <= {imem_addr[24:0], 7'h13};

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[24:0], 7'h13};
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = rom_word(pc);
        exp_q.push_back(e);
    endtask

    // Scoreboard: every completed transfer must match the next expected word, and
    // a stalled head must not change unless a redirect flushed it.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (hold_q && !redir_q)
                chk("hold_stable", {31'b0, out_valid, out_pc, out_instr}, {31'b0, hold_val});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", {64'b0, out_pc}, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pop_pc", {64'b0, out_pc}, {64'b0, e.pc});
                    chk("pop_instr", {64'b0, out_instr}, {64'b0, e.instr});
                end
            end
        end
        hold_q   = out_valid && !out_ready;
        redir_q  = redirect_valid;
        hold_val = {1'b1, out_pc, out_instr};
    end

    task automatic start(input bit rdy);
        mon_en         = 1'b0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        exp_q.delete();
        fetch_en       = 1'b1;
        out_ready      = rdy;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        rst_n  = 1'b1;
    endtask

    task automatic wait_empty(input string name, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 96'(exp_q.size()), 96'd0);
    endtask

    task automatic wait_pc(input logic [31:0] pc, input int bound);
        int n = 0;
        while (!(out_valid && out_pc == pc) && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_pc_reached", {95'b0, out_valid && out_pc == pc}, 96'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        vecs[0] = '{target: 32'h0000_0014, first_instr: 32'h0000_0A13, at_pc: 5, ready: 1'b1};
        vecs[1] = '{target: 32'hFFFF_FFFF, first_instr: 32'hFFFF_FF93, at_pc: 2, ready: 1'b1};
        vecs[2] = '{target: 32'h1234_5678, first_instr: 32'h1A2B_3C13, at_pc: 0, ready: 1'b0};
        vecs[3] = '{target: 32'h0000_0100, first_instr: 32'h0000_8013, at_pc: 0, ready: 1'b0};
        vecs[4] = '{target: 32'h0000_0000, first_instr: 32'h0000_0013, at_pc: 3, ready: 1'b1};

        // Reset values
        #1;
        chk("rst_addr",  {64'b0, imem_addr}, 96'd0);
        chk("rst_valid", {95'b0, out_valid}, 96'd0);
        chk("rst_instr", {64'b0, out_instr}, 96'd0);
        chk("rst_pc",    {64'b0, out_pc},    96'd0);

        // Streaming start-up: address advances every cycle, first word two edges in
        start(1'b1);
        chk("t1_addr0", {64'b0, imem_addr}, 96'd0);
        for (int i = 0; i < 6; i++) push_exp(32'(i));
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            chk("t1_addr", {64'b0, imem_addr}, 96'(i));
            chk("t1_valid", {95'b0, out_valid}, {95'b0, i >= 2});
            if (i == 2) begin
                chk("t1_first_pc",    {64'b0, out_pc},    96'd0);
                chk("t1_first_instr", {64'b0, out_instr}, 96'h13);
            end
        end
        wait_empty("t1_drain", 20);

        // Backpressure: buffer fills with pc 0,1 and the address freezes at 2
        start(1'b0);
        for (int i = 0; i < 4; i++) push_exp(32'(i));
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("t2_addr_frozen", {64'b0, imem_addr}, 96'd2);
        chk("t2_head_pc", {64'b0, out_pc}, 96'd0);
        chk("t2_valid", {95'b0, out_valid}, 96'd1);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("t2_nogap_valid", {95'b0, out_valid}, 96'd1);
            chk("t2_nogap_pc", {64'b0, out_pc}, 96'(j));
            @(posedge clk);
            #1;
        end
        chk("t2_drain", 96'(exp_q.size()), 96'd0);

        // Redirect vectors
        for (int v = 0; v < 5; v++) begin
            start(vecs[v].ready);
            if (vecs[v].ready) begin
                for (int i = 0; i <= vecs[v].at_pc; i++) push_exp(32'(i));
                wait_pc(32'(vecs[v].at_pc), 30);
            end else begin
                repeat (5) begin
                    @(posedge clk);
                    #1;
                end
                chk("rv_full_addr", {64'b0, imem_addr}, 96'd2);
            end
            redirect_valid = 1'b1;
            redirect_pc    = vecs[v].target;
            @(posedge clk);
            #1;
            redirect_valid = 1'b0;
            chk("rv_flushed", {95'b0, out_valid}, 96'd0);
            n = 1;
            while (!out_valid && n < 10) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("rv_latency", 96'(n), 96'd3);
            chk("rv_first_pc",    {64'b0, out_pc},    {64'b0, vecs[v].target});
            chk("rv_first_instr", {64'b0, out_instr}, {64'b0, vecs[v].first_instr});
            if (!vecs[v].ready) begin
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                chk("rv_hold_pc", {64'b0, out_pc}, {64'b0, vecs[v].target});
                chk("rv_hold_addr", {64'b0, imem_addr}, {64'b0, vecs[v].target + 32'd2});
            end
            for (int i = 0; i < 3; i++) push_exp(vecs[v].target + 32'(i));
            out_ready = 1'b1;
            wait_empty("rv_drain", 20);
        end

        // fetch_en low mid-stream, then asynchronous reset mid-cycle
        start(1'b1);
        for (int i = 0; i < 5; i++) push_exp(32'(i));
        wait_pc(32'd3, 30);
        fetch_en = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("t6_addr_hold", {64'b0, imem_addr}, 96'd5);
        end
        chk("t6_drained", 96'(exp_q.size()), 96'd0);
        chk("t6_idle", {95'b0, out_valid}, 96'd0);
        mon_en   = 1'b0;
        fetch_en = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {95'b0, out_valid}, 96'd0);
        chk("t6_rst_addr",  {64'b0, imem_addr}, 96'd0);
        chk("t6_rst_pc",    {64'b0, out_pc},    96'd0);
        chk("t6_rst_instr", {64'b0, out_instr}, 96'd0);
        @(posedge clk);
        #1;
        exp_q.delete();
        for (int i = 0; i < 3; i++) push_exp(32'(i));
        mon_en = 1'b1;
        rst_n  = 1'b1;
        wait_empty("t6_restart", 20);
        mon_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
